// File: rtl/aes_pkg.sv
// Shared AES byte-substitution constants: forward/inverse S-box tables and the mode type.
// Tables are indexed [row][column] with row = byte[7:4] and column = byte[3:0].
package aes_pkg;

   typedef enum logic {
      MODE_FWD = 1'b0,
      MODE_INV = 1'b1
   } mode_e;

   localparam logic [7:0] SBOX_FWD [16][16] = '{
      '{8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76},
      '{8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0},
      '{8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15},
      '{8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75},
      '{8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84},
      '{8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf},
      '{8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8},
      '{8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2},
      '{8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73},
      '{8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb},
      '{8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79},
      '{8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08},
      '{8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a},
      '{8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e},
      '{8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf},
      '{8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16}
   };

   localparam logic [7:0] SBOX_INV [16][16] = '{
      '{8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb},
      '{8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb},
      '{8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e},
      '{8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25},
      '{8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92},
      '{8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84},
      '{8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06},
      '{8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b},
      '{8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73},
      '{8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e},
      '{8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b},
      '{8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4},
      '{8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f},
      '{8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef},
      '{8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61},
      '{8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d}
   };

endpackage

// File: rtl/aes_sbox_lane.sv
// One byte lane of SubBytes: purely combinational forward or inverse S-box lookup.
module aes_sbox_lane
   import aes_pkg::*;
(
   input  logic [7:0] byte_i,
   input  mode_e      mode_i,
   output logic [7:0] byte_o
);

   always_comb begin
      if (mode_i == MODE_INV) begin
         byte_o = SBOX_INV[byte_i[7:4]][byte_i[3:0]];
      end else begin
         byte_o = SBOX_FWD[byte_i[7:4]][byte_i[3:0]];
      end
   end

endmodule

// File: rtl/sub_bytes_pipe.sv
// Valid/ready SubBytes pipeline: stage 1 captures the beat, lanes substitute combinationally,
// and an optional output register (OUT_REG) forms stage 2.
module sub_bytes_pipe
   import aes_pkg::*;
#(
   parameter int LANES   = 16,
   parameter int OUT_REG = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_mode,
   input  logic [8*LANES-1:0]   in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [8*LANES-1:0]   out_data,
   output logic [1:0]           inflight
);

   logic               s1Valid_q, s1Valid_d;
   mode_e              s1Mode_q, s1Mode_d;
   logic [8*LANES-1:0] s1Data_q, s1Data_d;
   logic [8*LANES-1:0] subData;
   logic               s2Load;
   logic               s1Load;

   for (genvar g = 0; g < LANES; g++) begin : gLane
      aes_sbox_lane uLane (
         .byte_i (s1Data_q[8*g +: 8]),
         .mode_i (s1Mode_q),
         .byte_o (subData[8*g +: 8])
      );
   end

   if (OUT_REG != 0) begin : gOutReg
      logic               outValid_q, outValid_d;
      logic [8*LANES-1:0] outData_q, outData_d;

      assign s2Load = s1Valid_q && (!outValid_q || out_ready);

      always_comb begin
         outValid_d = outValid_q;
         outData_d  = outData_q;
         if (flush) begin
            outValid_d = 1'b0;
         end else if (s2Load) begin
            outValid_d = 1'b1;
            outData_d  = subData;
         end else if (out_ready) begin
            outValid_d = 1'b0;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            outValid_q <= 1'b0;
            outData_q  <= '0;
         end else begin
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
         end
      end

      assign out_valid = outValid_q;
      assign out_data  = outData_q;
   end else begin : gOutComb
      // Without stage 2 the beat leaves straight from stage 1 when downstream takes it.
      assign s2Load    = s1Valid_q && out_ready;
      assign out_valid = s1Valid_q;
      assign out_data  = subData;
   end

   assign in_ready = !flush && (!s1Valid_q || s2Load);
   assign s1Load   = in_valid && in_ready;

   always_comb begin
      s1Valid_d = s1Valid_q;
      s1Mode_d  = s1Mode_q;
      s1Data_d  = s1Data_q;
      if (flush) begin
         s1Valid_d = 1'b0;
      end else if (s1Load) begin
         s1Valid_d = 1'b1;
         s1Mode_d  = mode_e'(in_mode);
         s1Data_d  = in_data;
      end else if (s2Load) begin
         s1Valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1Valid_q <= 1'b0;
         s1Mode_q  <= MODE_FWD;
         s1Data_q  <= '0;
      end else begin
         s1Valid_q <= s1Valid_d;
         s1Mode_q  <= s1Mode_d;
         s1Data_q  <= s1Data_d;
      end
   end

   assign inflight = {1'b0, s1Valid_q} + {1'b0, out_valid};

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Directed bench for sub_bytes_pipe: default 16-lane two-stage instance plus a
// LANES=1, OUT_REG=0 instance, with hand-computed S-box expectations.
module tb_sub_bytes_pipe;

   typedef struct {
      logic [127:0] din;
      logic         mode;
      logic [127:0] dout;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         flush = 1'b0;
   logic         inValid = 1'b0;
   logic         inReady;
   logic         inMode = 1'b0;
   logic [127:0] inData = '0;
   logic         outValid;
   logic         outReady = 1'b1;
   logic [127:0] outData;
   logic [1:0]   inflight;

   logic         sFlush = 1'b0;
   logic         sInValid = 1'b0;
   logic         sInReady;
   logic         sInMode = 1'b0;
   logic [7:0]   sInData = '0;
   logic         sOutValid;
   logic         sOutReady = 1'b1;
   logic [7:0]   sOutData;
   logic [1:0]   sInflight;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sub_bytes_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .in_mode   (inMode),
      .in_data   (inData),
      .out_valid (outValid),
      .out_ready (outReady),
      .out_data  (outData),
      .inflight  (inflight)
   );

   sub_bytes_pipe #(.LANES(1), .OUT_REG(0)) dutSmall (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (sFlush),
      .in_valid  (sInValid),
      .in_ready  (sInReady),
      .in_mode   (sInMode),
      .in_data   (sInData),
      .out_valid (sOutValid),
      .out_ready (sOutReady),
      .out_data  (sOutData),
      .inflight  (sInflight)
   );

   function automatic logic [127:0] rep4(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2, input logic [7:0] b3);
      logic [127:0] r;
      for (int j = 0; j < 4; j++) r[32*j +: 32] = {b3, b2, b1, b0};
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Presents one beat at a negedge into an empty pipe and waits for it to emerge.
   task automatic applyStimulus(input logic [127:0] d, input logic m,
                                output logic [127:0] q, output int lat);
      inData   = d;
      inMode   = m;
      inValid  = 1'b1;
      outReady = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      inValid = 1'b0;
      while (!outValid && lat < 10) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      q = outData;
   endtask

   // Fills the two-stage pipe with two beats while downstream is stalled.
   task automatic fillPipe();
      outReady = 1'b0;
      inValid  = 1'b1;
      inMode   = 1'b0;
      inData   = rep4(8'h01, 8'h02, 8'h03, 8'h04);
      @(posedge clk);
      @(negedge clk);
      inData = rep4(8'h05, 8'h06, 8'h07, 8'h08);
      @(posedge clk);
      @(negedge clk);
      inValid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, want finish");
      $fatal(1);
   end

   initial begin
      vec_t         vecs [6];
      logic [127:0] q;
      int           lat;
      logic [127:0] fwdOut [16];
      logic [127:0] orig;
      logic [7:0]   bpExp [10];
      logic [7:0]   sIn [4];
      logic [7:0]   sExp [4];

      vecs[0] = '{rep4(8'h00, 8'h53, 8'hff, 8'h01), 1'b0, rep4(8'h63, 8'hed, 8'h16, 8'h7c)};
      vecs[1] = '{rep4(8'h63, 8'hed, 8'h16, 8'h7c), 1'b1, rep4(8'h00, 8'h53, 8'hff, 8'h01)};
      vecs[2] = '{rep4(8'h10, 8'h20, 8'h30, 8'h40), 1'b0, rep4(8'hca, 8'hb7, 8'h04, 8'h09)};
      vecs[3] = '{rep4(8'hca, 8'hb7, 8'h04, 8'h09), 1'b1, rep4(8'h10, 8'h20, 8'h30, 8'h40)};
      vecs[4] = '{rep4(8'h0a, 8'ha0, 8'h5a, 8'hc3), 1'b0, rep4(8'h67, 8'he0, 8'hbe, 8'h2e)};
      vecs[5] = '{rep4(8'h67, 8'he0, 8'hbe, 8'h2e), 1'b1, rep4(8'h0a, 8'ha0, 8'h5a, 8'hc3)};

      bpExp = '{8'h7c, 8'h6a, 8'h7b, 8'h30, 8'h6b, 8'ha5, 8'hc5, 8'hbf, 8'h01, 8'ha3};
      sIn   = '{8'h53, 8'h00, 8'hff, 8'h10};
      sExp  = '{8'hed, 8'h63, 8'h16, 8'hca};

      // Reset state
      #12;
      checkOutput("reset out_valid", {127'd0, outValid}, 128'd0);
      checkOutput("reset inflight", {126'd0, inflight}, 128'd0);
      checkOutput("reset out_data", outData, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("reset in_ready", {127'd0, inReady}, 128'd1);
      @(negedge clk);

      // Table-driven spot checks with latency
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].din, vecs[i].mode, q, lat);
         checkOutput($sformatf("vec%0d data", i), q, vecs[i].dout);
         checkOutput($sformatf("vec%0d latency", i), 128'(lat), 128'd2);
      end
      @(negedge clk);

      // Round trip of all 256 byte values
      for (int b = 0; b < 16; b++) begin
         for (int i = 0; i < 16; i++) orig[8*i +: 8] = 8'(16*b + i);
         applyStimulus(orig, 1'b0, fwdOut[b], lat);
      end
      for (int b = 0; b < 16; b++) begin
         for (int i = 0; i < 16; i++) orig[8*i +: 8] = 8'(16*b + i);
         applyStimulus(fwdOut[b], 1'b1, q, lat);
         checkOutput($sformatf("roundtrip beat%0d", b), q, orig);
      end
      @(negedge clk);

      // Backpressure stream, alternating mode, random out_ready
      begin
         int           sent = 0;
         int           got = 0;
         int           cyc = 0;
         logic         stallPrev = 1'b0;
         logic [127:0] heldData = '0;
         logic         acc;
         logic         cons;
         while (got < 10 && cyc < 300) begin
            outReady = 1'($urandom_range(0, 1));
            if (sent < 10) begin
               inValid = 1'b1;
               inData  = {16{8'(sent + 1)}};
               inMode  = ((sent + 1) % 2 == 0);
            end else begin
               inValid = 1'b0;
            end
            #1;
            if (stallPrev) checkOutput("bp stall hold", outData, heldData);
            if (inflight == 2'd2 && !outReady) checkOutput("bp full in_ready", {127'd0, inReady}, 128'd0);
            if (inflight > 2'd2) checkOutput("bp inflight max", {126'd0, inflight}, 128'd2);
            acc  = inValid && inReady;
            cons = outValid && outReady;
            if (cons) begin
               checkOutput($sformatf("bp beat%0d", got + 1), outData, {16{bpExp[got]}});
               got++;
            end
            stallPrev = outValid && !outReady;
            heldData  = outData;
            @(posedge clk);
            if (acc) sent++;
            cyc++;
            @(negedge clk);
         end
         inValid  = 1'b0;
         outReady = 1'b1;
         checkOutput("bp beats received", 128'(got), 128'd10);
      end
      @(negedge clk);
      @(negedge clk);

      // Flush with a full pipe; the beat offered alongside flush must be dropped
      fillPipe();
      checkOutput("flush pre inflight", {126'd0, inflight}, 128'd2);
      flush   = 1'b1;
      inValid = 1'b1;
      inData  = rep4(8'h11, 8'h22, 8'h33, 8'h44);
      #1;
      checkOutput("flush in_ready", {127'd0, inReady}, 128'd0);
      @(posedge clk);
      @(negedge clk);
      flush   = 1'b0;
      inValid = 1'b0;
      checkOutput("flush out_valid", {127'd0, outValid}, 128'd0);
      checkOutput("flush inflight", {126'd0, inflight}, 128'd0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("flush no accept", {126'd0, inflight}, 128'd0);

      // Asynchronous reset mid-stream
      fillPipe();
      checkOutput("rst pre inflight", {126'd0, inflight}, 128'd2);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst async out_valid", {127'd0, outValid}, 128'd0);
      checkOutput("rst async inflight", {126'd0, inflight}, 128'd0);
      checkOutput("rst async out_data", outData, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(vecs[0].din, vecs[0].mode, q, lat);
      checkOutput("post-rst first data", q, vecs[0].dout);
      checkOutput("post-rst first latency", 128'(lat), 128'd2);
      @(negedge clk);

      // LANES=1, OUT_REG=0: latency 1 and one beat per cycle
      sOutReady = 1'b1;
      for (int k = 0; k <= 4; k++) begin
         if (k > 0) begin
            checkOutput($sformatf("small valid%0d", k - 1), {127'd0, sOutValid}, 128'd1);
            checkOutput($sformatf("small data%0d", k - 1), {120'd0, sOutData}, {120'd0, sExp[k-1]});
         end
         if (k < 4) begin
            sInValid = 1'b1;
            sInMode  = 1'b0;
            sInData  = sIn[k];
            #1;
            checkOutput($sformatf("small in_ready%0d", k), {127'd0, sInReady}, 128'd1);
         end else begin
            sInValid = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
      end
      checkOutput("small drained", {127'd0, sOutValid}, 128'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
